key_reader: RTL

//  Input-side companion to the LED pattern outputs: reads N raw push-button inputs and turns them into clean control events.
//  Per key: 2-flop synchroniser, debounce filter and press/hold FSM.

---
 rtl/key_reader.sv | 136 +++++++++++++
 1 files changed

// File: rtl/key_reader.sv
// rtl/key_reader.sv - push-button reader: synchroniser, debounce and press/long/repeat events per key
module key_reader #(
    parameter int N_KEYS          = 4,
    parameter int ACTIVE_LOW      = 1,
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int LONG_CYCLES     = 10000000,
    parameter int REPEAT_CYCLES   = 3000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_KEYS-1:0] KEY,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic [N_KEYS-1:0] key_long,
    output logic [N_KEYS-1:0] key_repeat,
    output logic              any_press
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PRESSED = 2'd1;
    localparam logic [1:0] ST_REPEAT  = 2'd2;

    localparam logic [31:0] DEB_LAST    = 32'(DEBOUNCE_CYCLES - 1);
    localparam logic [31:0] LONG_LAST   = 32'(LONG_CYCLES - 1);
    localparam logic [31:0] REPEAT_LAST = 32'(REPEAT_CYCLES - 1);

    logic [N_KEYS-1:0]       raw;
    logic [N_KEYS-1:0]       sync_a;
    logic [N_KEYS-1:0]       sync_b;
    logic [N_KEYS-1:0]       deb_done;
    logic [N_KEYS-1:0]       rise;
    logic [N_KEYS-1:0]       fall;
    logic [N_KEYS-1:0][31:0] deb_cnt;
    logic [N_KEYS-1:0][31:0] hold_cnt;
    logic [N_KEYS-1:0][1:0]  state;

    // Normalise so 1 always means pressed from here on.
    assign raw = (ACTIVE_LOW != 0) ? ~KEY : KEY;

    // Rise/fall are the cycle on which key_level is about to flip, so the
    // event pulses land on the same edge as the level change.
    always_comb begin
        deb_done = '0;
        rise     = '0;
        fall     = '0;
        for (int i = 0; i < N_KEYS; i++) begin
            deb_done[i] = (sync_b[i] != key_level[i]) && (deb_cnt[i] == DEB_LAST);
            rise[i]     = deb_done[i] & sync_b[i];
            fall[i]     = deb_done[i] & ~sync_b[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_a    <= '0;
            sync_b    <= '0;
            key_level <= '0;
            deb_cnt   <= '0;
        end else begin
            sync_a <= raw;
            sync_b <= sync_a;
            for (int i = 0; i < N_KEYS; i++) begin
                if (sync_b[i] == key_level[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_done[i]) begin
                    deb_cnt[i]   <= '0;
                    key_level[i] <= sync_b[i];
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 32'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= '0;
            hold_cnt    <= '0;
            key_press   <= '0;
            key_release <= '0;
            key_long    <= '0;
            key_repeat  <= '0;
        end else begin
            key_press   <= '0;
            key_release <= '0;
            key_long    <= '0;
            key_repeat  <= '0;
            for (int i = 0; i < N_KEYS; i++) begin
                case (state[i])
                    ST_IDLE: begin
                        hold_cnt[i] <= '0;
                        if (rise[i]) begin
                            state[i]     <= ST_PRESSED;
                            key_press[i] <= 1'b1;
                        end
                    end
                    ST_PRESSED: begin
                        if (fall[i]) begin
                            state[i]       <= ST_IDLE;
                            hold_cnt[i]    <= '0;
                            key_release[i] <= 1'b1;
                        end else if (hold_cnt[i] == LONG_LAST) begin
                            state[i]      <= ST_REPEAT;
                            hold_cnt[i]   <= '0;
                            key_long[i]   <= 1'b1;
                            key_repeat[i] <= 1'b1;
                        end else begin
                            hold_cnt[i] <= hold_cnt[i] + 32'd1;
                        end
                    end
                    ST_REPEAT: begin
                        // Release takes priority over a repeat due on the same cycle.
                        if (fall[i]) begin
                            state[i]       <= ST_IDLE;
                            hold_cnt[i]    <= '0;
                            key_release[i] <= 1'b1;
                        end else if (hold_cnt[i] == REPEAT_LAST) begin
                            hold_cnt[i]   <= '0;
                            key_repeat[i] <= 1'b1;
                        end else begin
                            hold_cnt[i] <= hold_cnt[i] + 32'd1;
                        end
                    end
                    default: begin
                        state[i]    <= ST_IDLE;
                        hold_cnt[i] <= '0;
                    end
                endcase
            end
        end
    end

    assign any_press = |key_press;

endmodule
